// File: rtl/iob_rst_seq_pkg.sv
// Shared types for the reset sequencer: FSM encoding, reset-cause codes and
// the cause priority encoder.
package iob_rst_seq_pkg;

  typedef enum logic [1:0] {
    ASSERT     = 2'd0,
    REL_PERIPH = 2'd1,
    RUN        = 2'd2
  } rst_state_e;

  typedef logic [1:0] rst_cause_t;

  localparam rst_cause_t CAUSE_POR  = 2'b00;
  localparam rst_cause_t CAUSE_SW   = 2'b01;
  localparam rst_cause_t CAUSE_TRAP = 2'b10;
  localparam rst_cause_t CAUSE_WDT  = 2'b11;

  // Watchdog beats trap beats software when several fire in the same cycle.
  function automatic rst_cause_t cause_sel(input logic wdt, input logic trap);
    if (wdt)       return CAUSE_WDT;
    else if (trap) return CAUSE_TRAP;
    else           return CAUSE_SW;
  endfunction

endpackage

// File: rtl/iob_rst_seq_if.sv
// Request/status bundle between the SoC control logic and the reset sequencer.
interface iob_rst_seq_if;
  logic       sw_rst_req;
  logic       trap;
  logic       trap_rst_en;
  logic       wdt_en;
  logic       wdt_kick;
  logic       periph_rst;
  logic       sys_rst;
  logic       rst_busy;
  logic [1:0] rst_cause;

  modport master (
    output sw_rst_req, trap, trap_rst_en, wdt_en, wdt_kick,
    input  periph_rst, sys_rst, rst_busy, rst_cause
  );

  modport slave (
    input  sw_rst_req, trap, trap_rst_en, wdt_en, wdt_kick,
    output periph_rst, sys_rst, rst_busy, rst_cause
  );
endinterface

// File: rtl/iob_rst_sync.sv
// Two-flop active-low reset synchronizer: asynchronous assert, synchronous
// release two clock edges after i_rst_n rises.
module iob_rst_sync (
  input  logic i_clk,
  input  logic i_rst_n,
  output logic o_srst_n
);

  logic [1:0] r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_sync <= 2'b00;
    else          r_sync <= {r_sync[0], 1'b1};
  end

  assign o_srst_n = r_sync[1];

endmodule

// File: rtl/iob_rst_sequencer.sv
// Board-reset sequencer: holds SoC in reset, releases peripherals before the
// CPU, restarts on sw/trap/watchdog. Watchdog built only with IOB_RST_SEQ_WDT_EN.
module iob_rst_sequencer
  import iob_rst_seq_pkg::*;
#(
  parameter int HOLD_CYCLES = 65535,
  parameter int STAGGER     = 16,
  parameter int CNT_W       = 16,
  parameter int WDT_TIMEOUT = 2**24-1,
  parameter int WDT_W       = 24
) (
  input  logic          clk,
  input  logic          rst_n,
  iob_rst_seq_if.slave  bus
);

  localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAG_LD = CNT_W'(STAGGER - 1);

  logic        w_srst_n;
  logic        w_wdt_evt;
  logic        w_trap_evt;
  logic        w_evt;
  rst_cause_t  w_cause;

  rst_state_e       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_periph_rst;
  logic             r_sys_rst;
  logic             r_rst_busy;
  rst_cause_t       r_rst_cause;

  iob_rst_sync u_sync (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .o_srst_n (w_srst_n)
  );

`ifdef IOB_RST_SEQ_WDT_EN
  localparam logic [WDT_W-1:0] WDT_LD = WDT_W'(WDT_TIMEOUT);

  logic [WDT_W-1:0] r_wdt;

  // Saturates at zero; leaving RUN on the resulting event reloads it.
  always_ff @(posedge clk or negedge w_srst_n) begin
    if (!w_srst_n)
      r_wdt <= WDT_LD;
    else if (r_state != RUN || !bus.wdt_en || bus.wdt_kick)
      r_wdt <= WDT_LD;
    else if (r_wdt != '0)
      r_wdt <= r_wdt - 1'b1;
  end

  // A kick in the expiry cycle suppresses the event.
  assign w_wdt_evt = (r_state == RUN) && bus.wdt_en && !bus.wdt_kick && (r_wdt == '0);
`else
  logic w_unused_wdt;
  assign w_unused_wdt = bus.wdt_en ^ bus.wdt_kick;
  assign w_wdt_evt    = 1'b0;
`endif

  assign w_trap_evt = bus.trap & bus.trap_rst_en;
  assign w_evt      = w_wdt_evt | w_trap_evt | bus.sw_rst_req;
  assign w_cause    = cause_sel(w_wdt_evt, w_trap_evt);

  // Events are only looked at in RUN; anything arriving mid-sequence is dropped.
  always_ff @(posedge clk or negedge w_srst_n) begin
    if (!w_srst_n) begin
      r_state      <= ASSERT;
      r_cnt        <= HOLD_LD;
      r_periph_rst <= 1'b1;
      r_sys_rst    <= 1'b1;
      r_rst_busy   <= 1'b1;
      r_rst_cause  <= CAUSE_POR;
    end else begin
      case (r_state)
        ASSERT: begin
          if (r_cnt == '0) begin
            r_state      <= REL_PERIPH;
            r_cnt        <= STAG_LD;
            r_periph_rst <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        REL_PERIPH: begin
          if (r_cnt == '0) begin
            r_state    <= RUN;
            r_sys_rst  <= 1'b0;
            r_rst_busy <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        RUN: begin
          if (w_evt) begin
            r_state      <= ASSERT;
            r_cnt        <= HOLD_LD;
            r_periph_rst <= 1'b1;
            r_sys_rst    <= 1'b1;
            r_rst_busy   <= 1'b1;
            r_rst_cause  <= w_cause;
          end
        end
        default: begin
          r_state      <= ASSERT;
          r_cnt        <= HOLD_LD;
          r_periph_rst <= 1'b1;
          r_sys_rst    <= 1'b1;
          r_rst_busy   <= 1'b1;
        end
      endcase
    end
  end

  assign bus.periph_rst = r_periph_rst;
  assign bus.sys_rst    = r_sys_rst;
  assign bus.rst_busy   = r_rst_busy;
  assign bus.rst_cause  = r_rst_cause;

endmodule

// File: tb/tb_iob_rst_sequencer.sv
// Directed bench for iob_rst_sequencer (HOLD=8, STAGGER=4, WDT=20); expected
// release edges and causes are queued at stimulus time and popped per sequence.
module tb_iob_rst_sequencer;
  import iob_rst_seq_pkg::*;

  typedef struct {
    string      tag;
    int         p_fall;
    int         s_fall;
    rst_cause_t cause;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  exp_t sb[$];

  iob_rst_seq_if bus();

  iob_rst_sequencer #(
    .HOLD_CYCLES (8),
    .STAGGER     (4),
    .CNT_W       (16),
    .WDT_TIMEOUT (20),
    .WDT_W       (24)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input int p, input int s, input rst_cause_t c);
    exp_t e;
    e.tag = tag; e.p_fall = p; e.s_fall = s; e.cause = c;
    sb.push_back(e);
  endtask

  // One-cycle software request; e = posedge that samples it.
  task automatic pulse_sw(output int e);
    @(negedge clk);
    bus.sw_rst_req = 1'b1;
    e = cyc + 1;
    @(negedge clk);
    bus.sw_rst_req = 1'b0;
  endtask

  // Follow one reset sequence to sys_rst release and score it against the queue.
  task automatic run_seq(output int s_at);
    exp_t e;
    int   p_at, busy_bad, t;
    logic [2:0] first;
    p_at = -1; s_at = -1; busy_bad = 0; t = 0;
    first = 3'bxxx;
    @(negedge clk);
    while (bus.sys_rst !== 1'b1 && t < 200) begin @(negedge clk); t++; end
    first = {bus.periph_rst, bus.sys_rst, bus.rst_busy};
    for (int i = 0; i < 100 && s_at < 0; i++) begin
      if (p_at < 0 && bus.periph_rst === 1'b0) p_at = cyc;
      if (bus.sys_rst === 1'b0) s_at = cyc;
      if (bus.rst_busy !== bus.sys_rst) busy_bad++;
      if (s_at < 0) @(negedge clk);
    end
    if (sb.size() == 0) begin
      e.tag = "empty"; e.p_fall = -2; e.s_fall = -2; e.cause = 2'bxx;
    end else begin
      e = sb.pop_front();
    end
    check({e.tag, "_start"}, 32'(first), 32'h7);
    check({e.tag, "_pfall"}, p_at, e.p_fall);
    check({e.tag, "_sfall"}, s_at, e.s_fall);
    check({e.tag, "_cause"}, 32'(bus.rst_cause), 32'(e.cause));
    check({e.tag, "_busy"}, busy_bad, 0);
  endtask

  // Window in which no reset may occur and cause must never read 11.
  task automatic idle_check(input string tag, input int n);
    int hits, wdt_cause;
    hits = 0; wdt_cause = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (bus.sys_rst !== 1'b0 || bus.periph_rst !== 1'b0) hits++;
      if (bus.rst_cause === CAUSE_WDT) wdt_cause++;
    end
    check({tag, "_noreset"}, hits, 0);
    check({tag, "_nowdtcause"}, wdt_cause, 0);
  endtask

  initial begin
    int e, s, base;
    bus.sw_rst_req = 1'b0; bus.trap = 1'b0; bus.trap_rst_en = 1'b0;
    bus.wdt_en = 1'b0; bus.wdt_kick = 1'b0;

    // Power-on reset
    #1 rst_n = 1'b0;
    repeat (5) @(negedge clk);
    check("por_periph", 32'(bus.periph_rst), 1);
    check("por_sys", 32'(bus.sys_rst), 1);
    check("por_busy", 32'(bus.rst_busy), 1);
    check("por_cause", 32'(bus.rst_cause), 32'(CAUSE_POR));
    rst_n = 1'b1;
    base = cyc;
    push("por", base + 10, base + 14, CAUSE_POR);
    run_seq(s);

    // Software reset
    pulse_sw(e);
    push("sw", e + 8, e + 12, CAUSE_SW);
    run_seq(s);

    // Trap masked by trap_rst_en=0
    @(negedge clk);
    bus.trap = 1'b1;
    idle_check("trapmask", 20);
    bus.trap = 1'b0;

    // Trap and software in the same cycle: trap wins
    @(negedge clk);
    bus.trap = 1'b1; bus.trap_rst_en = 1'b1; bus.sw_rst_req = 1'b1;
    e = cyc + 1;
    @(negedge clk);
    bus.trap = 1'b0; bus.sw_rst_req = 1'b0;
    push("prio", e + 8, e + 12, CAUSE_TRAP);
    run_seq(s);

    // Software request during ASSERT is dropped and does not stretch the hold
    pulse_sw(e);
    push("swhold", e + 8, e + 12, CAUSE_SW);
    repeat (3) @(negedge clk);
    bus.sw_rst_req = 1'b1;
    @(negedge clk);
    bus.sw_rst_req = 1'b0;
    run_seq(s);

    // Trap held high across a restart retriggers on first RUN cycle
    @(negedge clk);
    bus.trap = 1'b1;
    e = cyc + 1;
    push("traplvl", e + 8, e + 12, CAUSE_TRAP);
    run_seq(s);
    @(negedge clk);
    bus.trap = 1'b0;
    push("traprep", s + 9, s + 13, CAUSE_TRAP);
    run_seq(s);

`ifdef IOB_RST_SEQ_WDT_EN
    // Unkicked watchdog: counter 20 at RUN entry, hits 0 after 20 edges
    bus.wdt_en = 1'b1;
    push("wdt", s + 29, s + 33, CAUSE_WDT);
    run_seq(s);
    for (int i = 0; i < 200; i++) begin
      bus.wdt_kick = (i % 15 == 14);
      @(negedge clk);
      check("wdtkick_run", 32'(bus.sys_rst), 0);
    end
    bus.wdt_kick = 1'b1;
    @(negedge clk);
    bus.wdt_kick = 1'b0;
    repeat (20) @(negedge clk);
    bus.wdt_kick = 1'b1;
    @(negedge clk);
    bus.wdt_kick = 1'b0;
    bus.wdt_en = 1'b0;
    check("wdtexp_cause", 32'(bus.rst_cause), 32'(CAUSE_WDT));
    idle_check("wdtexp", 30);
`else
    bus.wdt_en = 1'b1;
    idle_check("nowdt", 500);
    bus.wdt_en = 1'b0;
    check("nowdt_cause", 32'(bus.rst_cause), 32'(CAUSE_TRAP));
`endif

    // Board reset asserted during REL_PERIPH
    pulse_sw(e);
    repeat (8) @(negedge clk);
    check("async_pre_periph", 32'(bus.periph_rst), 0);
    check("async_pre_cause", 32'(bus.rst_cause), 32'(CAUSE_SW));
    #2 rst_n = 1'b0;
    #1;
    check("async_periph", 32'(bus.periph_rst), 1);
    check("async_sys", 32'(bus.sys_rst), 1);
    check("async_busy", 32'(bus.rst_busy), 1);
    check("async_cause", 32'(bus.rst_cause), 32'(CAUSE_POR));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    base = cyc;
    push("rerst", base + 10, base + 14, CAUSE_POR);
    run_seq(s);

    check("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/iob_rst_sequencer.md
# iob_rst_sequencer

Reset manager between the board reset pin and the SoC. It synchronizes the external reset and holds the SoC in reset for a programmable number of cycles. It then releases the peripherals (UART, GPIO) before the CPU subsystem, and re-enters the sequence on a software request, a CPU trap, or a watchdog timeout. It replaces ad-hoc reset counters at the top level and reports the cause of the last reset.

## Interface
- HOLD_CYCLES, 65535: cycles both resets stay asserted after the synchronized release or an internal reset event; must be ≥1.
- STAGGER, 16: cycles between `periph_rst` release and `sys_rst` release; must be ≥1.
- CNT_W, 16: width of the hold/stagger counter; must hold max(HOLD_CYCLES, STAGGER)-1.
- WDT_TIMEOUT, 2**24-1: watchdog reload value, in cycles.
- WDT_W, 24: watchdog counter width.
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low board reset
- sw_rst_req  in  1  single-cycle software reset request from a CPU-mapped register
- trap  in  1  CPU trap flag, level
- trap_rst_en  in  1  when 1, `trap` triggers a reset
- wdt_en  in  1  runtime watchdog enable
- wdt_kick  in  1  single-cycle watchdog reload
- periph_rst  out  1  active-high reset to UART/GPIO
- sys_rst  out  1  active-high reset to the CPU/memory subsystem
- rst_busy  out  1  1 whenever the sequencer is not in RUN
- rst_cause  out  2  cause of the last reset: 00 pin/POR, 01 software, 10 trap, 11 watchdog

## Operation
- `rst_n` passes through a 2-flop synchronizer: asynchronous assert, synchronous deassert. Its output (`srst_n`) resets all internal state.
- Values while `srst_n`=0: state=ASSERT, cnt=HOLD_CYCLES-1, periph_rst=1, sys_rst=1, rst_busy=1, rst_cause=00, wdt counter=WDT_TIMEOUT.
- FSM states and transitions:
  - ASSERT: cnt decrements each cycle. At cnt==0, go to REL_PERIPH, load cnt=STAGGER-1, and clear periph_rst.
  - REL_PERIPH: cnt decrements each cycle. At cnt==0, go to RUN and clear sys_rst and rst_busy.
  - RUN: on any event, go to ASSERT, set periph_rst=1, sys_rst=1 and rst_busy=1, load cnt=HOLD_CYCLES-1, and write rst_cause.
- Events are sampled only in RUN. Events in ASSERT or REL_PERIPH are ignored and not queued.
- Event priority when simultaneous: watchdog (11) > trap (10) > software (01).
- Trap event: `trap & trap_rst_en` in RUN, level-sensitive. A trap still high after the restart retriggers only once RUN is reached again.
- rst_cause is cleared only by `rst_n`. It survives internal resets so boot firmware can read it.
- Watchdog counter:
  - Reloads to WDT_TIMEOUT when not in RUN, when wdt_en=0, or when wdt_kick=1.
  - Otherwise decrements in RUN.
  - Reaching 0 while in RUN with wdt_en=1 is a watchdog event. The counter does not wrap.

## Timing
- All outputs are registered.
- Any event cycle → periph_rst and sys_rst are 1 on the next edge.
- After `rst_n` rises, srst_n deasserts 2 edges later.
- periph_rst falls HOLD_CYCLES cycles after entering ASSERT.
- sys_rst falls STAGGER cycles after periph_rst falls.
- Internal event to sys_rst release: 1 + HOLD_CYCLES + STAGGER cycles.
- `rst_n` asserted mid-sequence: all outputs return to reset values asynchronously and the sequence restarts from ASSERT.
- wdt_kick on the same cycle the counter would hit 0: the kick wins and no event occurs.

## Configuration
- `IOB_RST_SEQ_WDT_EN` defined: watchdog counter and event logic are compiled in.
- Macro absent: no watchdog counter. wdt_en and wdt_kick are present but ignored, and cause 11 is never produced.

## Structure
- Shared package `iob_rst_seq_pkg` holds:
  - FSM state encoding: ASSERT=2'd0, REL_PERIPH=2'd1, RUN=2'd2.
  - Cause constants: CAUSE_POR, CAUSE_SW, CAUSE_TRAP, CAUSE_WDT.
- One sub-module, `iob_rst_sync`: a parameterless 2-flop active-low reset synchronizer instantiated on `rst_n`.

## Test plan
Use HOLD_CYCLES=8, STAGGER=4, WDT_TIMEOUT=20.
- Power-on: rst_n low 5 cycles, then high.
  - periph_rst falls on edge 2+8 after release.
  - sys_rst falls 4 edges later.
  - rst_cause=00, rst_busy falls together with sys_rst.
- Software reset: one-cycle sw_rst_req in RUN.
  - Both resets are 1 next edge; sys_rst releases 13 cycles after the request.
  - rst_cause=01.
- Trap and priority:
  - trap=1 with trap_rst_en=0 → no reset.
  - trap=1 with trap_rst_en=1 plus simultaneous sw_rst_req → rst_cause=10.
  - sw_rst_req during ASSERT → ignored, no extension of hold.
- Watchdog (macro on):
  - wdt_en=1, no kicks → event 20 cycles into RUN, rst_cause=11.
  - Kicks every 15 cycles → no reset for 200 cycles.
  - Kick on the expiry cycle → no reset.
- Async reset mid-sequence: rst_n low during REL_PERIPH.
  - periph_rst=1 immediately, without waiting for a clock edge.
  - rst_cause cleared to 00; full hold restarts.
- Macro off: wdt_en=1, no kicks for 500 cycles → no reset; rst_cause never 11.
